// File: rtl/hazard_if.sv
// Pipeline-to-hazard-unit bundle: register numbers and stage flags in, stall/flush/forward controls out.
// The pipeline drives the master side; the hazard controller sits on the slave side.
interface hazard_if;
   logic [4:0]  RsD, RtD;
   logic [4:0]  RsE, RtE, WriteRegE;
   logic        RegWriteE, MemtoRegE;
   logic [4:0]  WriteRegM;
   logic        RegWriteM;
   logic [4:0]  WriteRegW;
   logic        RegWriteW;
   logic        BranchTakenE, JumpD, MdStartE, MfhiD;
   logic        StallF, StallD, FlushD, FlushE, MdBusy;
   logic [1:0]  ForwardAE, ForwardBE;
   logic [15:0] StallCount;

   modport master (
      output RsD, RtD, RsE, RtE, WriteRegE, RegWriteE, MemtoRegE,
             WriteRegM, RegWriteM, WriteRegW, RegWriteW,
             BranchTakenE, JumpD, MdStartE, MfhiD,
      input  StallF, StallD, FlushD, FlushE, MdBusy, ForwardAE, ForwardBE, StallCount
   );

   modport slave (
      input  RsD, RtD, RsE, RtE, WriteRegE, RegWriteE, MemtoRegE,
             WriteRegM, RegWriteM, WriteRegW, RegWriteW,
             BranchTakenE, JumpD, MdStartE, MfhiD,
      output StallF, StallD, FlushD, FlushE, MdBusy, ForwardAE, ForwardBE, StallCount
   );
endinterface

// File: rtl/hazard_ctrl.sv
// 5-stage pipeline hazard unit: operand forwarding, load-use and HI/LO stalls, branch/jump flushes,
// a multiply/divide occupancy tracker and a saturating stall-cycle counter.
module hazard_ctrl #(
   parameter int unsigned MD_LAT = 8
) (
   input logic     clk,
   input logic     rst_n,
   hazard_if.slave hif
);

   typedef enum logic {MD_IDLE, MD_BUSY} md_state_e;

   localparam logic [4:0] MD_RELOAD = 5'(MD_LAT - 1);

   md_state_e   md_state_q, md_state_d;
   logic [4:0]  mdcnt_q, mdcnt_d;
   logic [15:0] stall_count_q, stall_count_d;
   logic        lwstall, mdstall, stall, md_busy;

   function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                          input logic       reg_write_m, input logic [4:0] write_reg_m,
                                          input logic       reg_write_w, input logic [4:0] write_reg_w);
      if (reg_write_m && write_reg_m != 5'd0 && write_reg_m == src)      return 2'b10;
      else if (reg_write_w && write_reg_w != 5'd0 && write_reg_w == src) return 2'b01;
      else                                                               return 2'b00;
   endfunction

   // Reset is folded into every control so the pipeline sees a clean flush while rst_n is low,
   // even though the state itself is only cleared on the clock edge.
   always_comb begin
      md_busy = rst_n && (md_state_q == MD_BUSY);
      lwstall = hif.MemtoRegE && hif.RegWriteE && (hif.WriteRegE != 5'd0) &&
                ((hif.WriteRegE == hif.RsD) || (hif.WriteRegE == hif.RtD));
      mdstall = hif.MfhiD && (md_busy || hif.MdStartE);
      stall   = rst_n && (lwstall || mdstall) && !hif.BranchTakenE;

      hif.StallF     = stall;
      hif.StallD     = stall;
      hif.FlushE     = !rst_n || stall || hif.BranchTakenE;
      hif.FlushD     = !rst_n || hif.BranchTakenE || (hif.JumpD && !stall);
      hif.ForwardAE  = rst_n ? fwd_sel(hif.RsE, hif.RegWriteM, hif.WriteRegM, hif.RegWriteW, hif.WriteRegW)
                             : 2'b00;
      hif.ForwardBE  = rst_n ? fwd_sel(hif.RtE, hif.RegWriteM, hif.WriteRegM, hif.RegWriteW, hif.WriteRegW)
                             : 2'b00;
      hif.MdBusy     = md_busy;
      hif.StallCount = stall_count_q;
   end

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      md_state_d    = md_state_q;
      mdcnt_d       = mdcnt_q;
      stall_count_d = stall_count_q;

      case (md_state_q)
         MD_IDLE: begin
            if (hif.MdStartE) begin
               md_state_d = MD_BUSY;
               mdcnt_d    = MD_RELOAD;
            end
         end
         MD_BUSY: begin
            if (hif.MdStartE)          mdcnt_d    = MD_RELOAD;
            else if (mdcnt_q != 5'd0)  mdcnt_d    = mdcnt_q - 5'd1;
            else                       md_state_d = MD_IDLE;
         end
         default: md_state_d = MD_IDLE;
      endcase

      if (stall && stall_count_q != 16'hFFFF) stall_count_d = stall_count_q + 16'd1;
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         md_state_q    <= MD_IDLE;
         mdcnt_q       <= 5'd0;
         stall_count_q <= 16'd0;
      end else begin
         md_state_q    <= md_state_d;
         mdcnt_q       <= mdcnt_d;
         stall_count_q <= stall_count_d;
      end
   end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter MD_LAT, default 8: number of cycles a multiply/divide occupies the HI/LO unit; legal range 2..32.
REQ-002 clk  in  1  sole clock; all state updates on posedge clk.
REQ-003 rst_n  in  1  reset; synchronous, active-low.
REQ-004 RsD, RtD  in  5 each  source register numbers of the instruction in ID.
REQ-005 RsE, RtE, WriteRegE  in  5 each  sources and destination of the instruction in EX.
REQ-006 RegWriteE, MemtoRegE  in  1 each  EX-stage write-enable and load flag.
REQ-007 WriteRegM, RegWriteM  in  5, 1  MEM-stage destination and write-enable.
REQ-008 WriteRegW, RegWriteW  in  5, 1  WB-stage destination and write-enable.
REQ-009 BranchTakenE  in  1  branch in EX resolved as taken this cycle.
REQ-010 JumpD  in  1  jump decoded in ID this cycle.
REQ-011 MdStartE  in  1  single-cycle pulse: mult/div in EX starts this cycle.
REQ-012 MfhiD  in  1  instruction in ID reads HI/LO (mfhi/mflo).
REQ-013 StallF, StallD  out  1 each  hold the PC and the IF/ID register.
REQ-014 FlushD  out  1  clear the IF/ID register.
REQ-015 FlushE  out  1  drives the ID/EX register CLR input.
REQ-016 ForwardAE, ForwardBE  out  2 each  EX operand select: 00 register file, 01 WB result, 10 MEM result.
REQ-017 MdBusy  out  1  HI/LO unit busy.
REQ-018 StallCount  out  16  number of stall cycles since reset.

Function
REQ-019 ForwardAE shall be 10 if RegWriteM, WriteRegM!=0 and WriteRegM==RsE; else 01 if RegWriteW, WriteRegW!=0 and WriteRegW==RsE; else 00. MEM takes priority over WB.
REQ-020 ForwardBE shall follow the REQ-019 rule with RtE in place of RsE.
REQ-021 lwstall shall be 1 when MemtoRegE, RegWriteE and WriteRegE!=0 all hold and WriteRegE equals RsD or RtD.
REQ-022 mdstall shall be 1 when MfhiD holds and either MdBusy or MdStartE is 1.
REQ-023 stall = (lwstall OR mdstall) AND NOT BranchTakenE.
REQ-024 StallF = StallD = stall.
REQ-025 FlushE = stall OR BranchTakenE.
REQ-026 FlushD = BranchTakenE OR (JumpD AND NOT stall).
REQ-027 REQ-019 to REQ-026 shall be combinational, with zero-cycle latency from inputs to outputs.
REQ-028 The multiply/divide tracker shall be an FSM with states IDLE and BUSY and a 5-bit down-counter mdcnt.
REQ-029 IDLE with MdStartE=1 shall go to BUSY with mdcnt=MD_LAT-1.
REQ-030 BUSY with MdStartE=1 shall restart: mdcnt=MD_LAT-1 and the FSM stays in BUSY.
REQ-031 BUSY with MdStartE=0 and mdcnt!=0 shall decrement mdcnt.
REQ-032 BUSY with MdStartE=0 and mdcnt==0 shall go to IDLE.
REQ-033 MdBusy shall be 1 exactly when the FSM is in BUSY, so it stays high for MD_LAT cycles after the MdStartE edge.
REQ-034 StallCount shall increment by 1 on each posedge where stall=1 and saturate at 16'hFFFF, with no wrap.
REQ-035 BranchTakenE overrides every stall: F and D advance, and D and E are flushed.

Reset
REQ-036 On a posedge with rst_n=0: FSM goes to IDLE, mdcnt=0, StallCount=0.
REQ-037 While rst_n=0: StallF=StallD=0, FlushD=FlushE=1, ForwardAE=ForwardBE=00, MdBusy=0, regardless of other inputs.
REQ-038 Reset asserted during BUSY shall abort the operation; after release MdBusy=0 and MfhiD causes no stall.
REQ-039 The first posedge with rst_n=1 shall resume normal operation with no extra latency.

Verification
REQ-040 Forwarding: RegWriteM=1, WriteRegM=5, RegWriteW=1, WriteRegW=5, RsE=5, RtE=0 -> ForwardAE=10, ForwardBE=00; then RegWriteM=0 -> ForwardAE=01.
REQ-041 Load-use: MemtoRegE=RegWriteE=1, WriteRegE=8, RtD=8 -> StallF=StallD=FlushE=1, FlushD=0; StallCount increments by 1; WriteRegE=0 instead -> no stall.
REQ-042 Branch over stall: lwstall condition held and BranchTakenE=1 -> StallF=StallD=0, FlushD=FlushE=1; StallCount unchanged.
REQ-043 Mult/div: MD_LAT=8, MdStartE pulse at cycle 0 -> MdBusy=1 during cycles 1..8, 0 at cycle 9; MfhiD=1 at cycles 0..8 stalls, and at cycle 9 it does not.
REQ-044 Restart and reset: second MdStartE at cycle 4 -> MdBusy holds through cycle 12; rst_n=0 at cycle 6 -> MdBusy=0 at cycle 7, and FlushE=1 while rst_n=0.
REQ-045 Saturation: hold the lwstall condition for 65540 cycles -> StallCount reads 16'hFFFF and holds.
